// File: rtl/edge_interval_meter.sv
// edge_interval_meter: measures the clk_100m cycle count between successive
// rising edges of an already-synchronized input, emits timeout records when
// edges stop arriving, and presents each result on a single-entry valid/ready
// output register. Results that arrive while the output is still occupied are
// discarded and counted in a saturating drop counter.
module edge_interval_meter #(
  parameter int          CNT_W   = 32,
  parameter int unsigned TIMEOUT = 100_000_000,
  parameter int          DROP_W  = 16
) (
  input  logic              clk_100m,
  input  logic              rst_n,
  input  logic              signal_in,
  output logic [CNT_W-1:0]  meas_data,
  output logic              meas_timeout,
  output logic              meas_valid,
  input  logic              meas_ready,
  output logic [DROP_W-1:0] drop_count,
  output logic              armed
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   counter;
  logic [CNT_W-1:0]   counter_next;
  logic               prev;
  logic               rise;
  logic               cand_valid;
  logic [CNT_W-1:0]   cand_data;
  logic               cand_timeout;
  logic               load_ok;

  assign rise    = signal_in & ~prev;
  assign load_ok = ~meas_valid | meas_ready;

  // Previous-sample register used for single-cycle rising-edge detection.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else begin
      prev <= signal_in;
    end
  end

  // Interval state machine: decides the next state/counter and whether a
  // result candidate (measured interval or timeout) is produced this cycle.
  // A rise takes priority over a coincident counter == TIMEOUT.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    cand_valid   = 1'b0;
    cand_data    = counter;
    cand_timeout = 1'b0;
    case (state)
      IDLE: begin
        counter_next = '0;
        if (rise) begin
          counter_next = CNT_W'(1);
          state_next   = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          cand_valid   = 1'b1;
          cand_data    = counter;
          counter_next = CNT_W'(1);
        end else if (counter == TIMEOUT_CNT) begin
          cand_valid   = 1'b1;
          cand_data    = TIMEOUT_CNT;
          cand_timeout = 1'b1;
          counter_next = '0;
          state_next   = IDLE;
        end else begin
          counter_next = counter + 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        counter_next = '0;
      end
    endcase
  end

  // State, counter and the registered armed status flag.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      counter <= '0;
      armed   <= 1'b0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
      armed   <= (state_next == MEASURE);
    end
  end

  // Single-entry output register: loads a candidate when empty or being
  // drained this cycle, otherwise discards it and bumps the drop counter.
  // The held record never changes while it waits for meas_ready.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      meas_valid   <= 1'b0;
      meas_data    <= '0;
      meas_timeout <= 1'b0;
      drop_count   <= '0;
    end else begin
      if (cand_valid) begin
        if (load_ok) begin
          meas_valid   <= 1'b1;
          meas_data    <= cand_data;
          meas_timeout <= cand_timeout;
        end else if (drop_count != {DROP_W{1'b1}}) begin
          drop_count <= drop_count + 1'b1;
        end
      end else if (meas_valid && meas_ready) begin
        meas_valid <= 1'b0;
      end
    end
  end

endmodule
